// File: rtl/layer_seq_if.sv
// Handshake bundle for one sequential dense layer: parameter load port,
// input-vector port and result port, each valid/ready.
interface layer_seq_if #(
    parameter int N  = 16,
    parameter int SX = 99,
    parameter int SL = 99
);
    logic              ld_valid;
    logic              ld_ready;
    logic [N-1:0]      ld_data;
    logic              loaded;
    logic              in_valid;
    logic              in_ready;
    logic [N*SX-1:0]   nx;
    logic              out_valid;
    logic              out_ready;
    logic [N*SL-1:0]   ly;
    logic [N*SL-1:0]   lz;

    modport master (
        output ld_valid, ld_data, in_valid, nx, out_ready,
        input  ld_ready, loaded, in_ready, out_valid, ly, lz
    );
    modport slave (
        input  ld_valid, ld_data, in_valid, nx, out_ready,
        output ld_ready, loaded, in_ready, out_valid, ly, lz
    );
endinterface

// File: rtl/layer_seq.sv
// Time-multiplexed dense layer: SL nodes, one MAC each, walking the SX inputs
// serially; weights/biases streamed in node-major order over a word port.
module layer_seq_node #(
    parameter int SX  = 99,
    parameter int ACT = 1,
    parameter int SAT = 1,
    parameter int N   = 16,
    parameter int F   = 8,
    parameter int KW  = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [KW-1:0] widx,
    input  logic [N-1:0]  wdata,
    input  logic          clr,
    input  logic          mac,
    input  logic          fin,
    input  logic [KW-1:0] k,
    input  logic [N-1:0]  x,
    output logic [N-1:0]  y,
    output logic [N-1:0]  z
);
    localparam int PW = 2 * N;
    localparam int AW = PW + $clog2(SX + 1);
    localparam int SW = AW + 1;

    // Entries 0..SX-1 are weights, entry SX is the bias.
    logic signed [N-1:0]  wmem [SX+1];
    logic signed [N-1:0]  xs, wk, bias;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic signed [SW-1:0] sum, sh;
    logic                 ovf;
    logic [N-1:0]         zr;

    always_ff @(posedge clk)
        if (we) wmem[widx] <= wdata;

    assign xs   = x;
    assign wk   = wmem[k];
    assign bias = wmem[KW'(SX)];
    assign prod = PW'(xs) * PW'(wk);
    assign sum  = SW'(acc) + (SW'(bias) <<< F);
    assign sh   = sum >>> F;
    // Overflow when the bits above the n-bit sign position disagree.
    assign ovf  = ~(&sh[SW-1:N-1] | ~|sh[SW-1:N-1]);

    always_comb begin
        zr = sh[N-1:0];
        if (SAT != 0 && ovf)
            zr = sh[SW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            y   <= '0;
            z   <= '0;
        end else begin
            if (clr)      acc <= '0;
            else if (mac) acc <= acc + AW'(prod);
            if (fin) begin
                z <= zr;
                y <= (ACT == 1 && zr[N-1]) ? '0 : zr;
            end
        end
    end
endmodule

module layer_seq #(
    parameter int SX  = 99,
    parameter int SL  = 99,
    parameter int ACT = 1,
    parameter int SAT = 1,
    parameter int N   = 16,
    parameter int F   = 8
) (
    input logic       clk,
    input logic       rst,
    layer_seq_if.slave bus
);
    localparam int KW = $clog2(SX + 1);
    localparam int JW = (SL > 1) ? $clog2(SL) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t state, state_nx;

    logic [KW-1:0]        k, ld_k;
    logic [JW-1:0]        ld_j;
    logic [SX-1:0][N-1:0] xsr;
    logic                 ld_rdy, in_rdy, ld_fire, ld_first, ld_last;
    logic                 clr, mac, fin, loaded_q, out_valid_q;

    always_ff @(posedge clk)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx = state;
        ld_rdy   = 1'b0;
        in_rdy   = 1'b0;
        clr      = 1'b0;
        mac      = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                ld_rdy = 1'b1;
                // A pending load word takes priority over a new vector.
                in_rdy = loaded_q & ~bus.ld_valid;
                if (bus.in_valid & in_rdy) begin
                    clr      = 1'b1;
                    state_nx = COMPUTE;
                end
            end
            COMPUTE: begin
                if (k == KW'(SX)) begin
                    fin      = 1'b1;
                    state_nx = DONE;
                end else begin
                    mac = 1'b1;
                end
            end
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ld_fire  = bus.ld_valid & ld_rdy;
    assign ld_first = ld_fire & (ld_k == '0) & (ld_j == '0);
    assign ld_last  = ld_fire & (ld_k == KW'(SX)) & (ld_j == JW'(SL - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_k        <= '0;
            ld_j        <= '0;
            k           <= '0;
            loaded_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (ld_fire) begin
                if (ld_k == KW'(SX)) begin
                    ld_k <= '0;
                    ld_j <= (ld_j == JW'(SL - 1)) ? '0 : ld_j + JW'(1);
                end else begin
                    ld_k <= ld_k + KW'(1);
                end
            end
            if (ld_last)       loaded_q <= 1'b1;
            else if (ld_first) loaded_q <= 1'b0;
            if (clr)      k <= '0;
            else if (mac) k <= k + KW'(1);
            if (fin)                                 out_valid_q <= 1'b1;
            else if (state == DONE && bus.out_ready) out_valid_q <= 1'b0;
        end
    end

    // Latched vector shifts down one element per MAC so x[k] is always slot 0.
    always_ff @(posedge clk)
        if (clr)      xsr <= bus.nx;
        else if (mac) xsr <= xsr >> N;

    assign bus.ld_ready  = ld_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.loaded    = loaded_q;
    assign bus.out_valid = out_valid_q;

    for (genvar j = 0; j < SL; j++) begin : g_node
        layer_seq_node #(
            .SX(SX), .ACT(ACT), .SAT(SAT), .N(N), .F(F), .KW(KW)
        ) u_node (
            .clk   (clk),
            .rst   (rst),
            .we    (ld_fire && (ld_j == JW'(j))),
            .widx  (ld_k),
            .wdata (bus.ld_data),
            .clr   (clr),
            .mac   (mac),
            .fin   (fin),
            .k     (k),
            .x     (xsr[0]),
            .y     (bus.ly[j*N +: N]),
            .z     (bus.lz[j*N +: N])
        );
    end
endmodule

// File: tb/tb_layer_seq.sv
// Directed + randomized bench for layer_seq against an integer reference model.
module tb_layer_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_seq_if #(.N(16), .SX(3), .SL(2)) ba();
    layer_seq_if #(.N(16), .SX(2), .SL(1)) bb();
    layer_seq_if #(.N(16), .SX(2), .SL(1)) bc();

    layer_seq #(.SX(3), .SL(2), .ACT(1), .SAT(1), .N(16), .F(8)) ua (.clk(clk), .rst(rst), .bus(ba.slave));
    layer_seq #(.SX(2), .SL(1), .ACT(0), .SAT(1), .N(16), .F(8)) ub (.clk(clk), .rst(rst), .bus(bb.slave));
    layer_seq #(.SX(2), .SL(1), .ACT(0), .SAT(0), .N(16), .F(8)) uc (.clk(clk), .rst(rst), .bus(bc.slave));

    // Wrap-mode twin sees exactly the saturating instance's stimulus.
    assign bc.ld_valid  = bb.ld_valid;
    assign bc.ld_data   = bb.ld_data;
    assign bc.in_valid  = bb.in_valid;
    assign bc.nx        = bb.nx;
    assign bc.out_ready = bb.out_ready;

    int nerr = 0;
    int nchk = 0;
    int wa [2][4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: real-valued sum scaled by 2^8, floor-divide, clamp or wrap.
    function automatic logic [15:0] red(input longint s, input bit sat);
        longint t;
        t = s >>> 8;
        if (sat) begin
            if (t > 32767)  t = 32767;
            if (t < -32768) t = -32768;
        end
        return t[15:0];
    endfunction

    function automatic logic [31:0] mdl_lz(input logic [47:0] v);
        logic [31:0] r;
        longint s;
        for (int j = 0; j < 2; j++) begin
            s = longint'(wa[j][3]) * 256;
            for (int k = 0; k < 3; k++)
                s += longint'($signed(v[k*16 +: 16])) * longint'(wa[j][k]);
            r[j*16 +: 16] = red(s, 1'b1);
        end
        return r;
    endfunction

    function automatic logic [31:0] mdl_ly(input logic [31:0] z);
        logic [31:0] r;
        for (int j = 0; j < 2; j++)
            r[j*16 +: 16] = z[j*16 + 15] ? 16'h0 : z[j*16 +: 16];
        return r;
    endfunction

    function automatic logic [47:0] rand_vec();
        logic [47:0] v;
        for (int k = 0; k < 3; k++) v[k*16 +: 16] = 16'($urandom_range(0, 4095) - 2048);
        return v;
    endfunction

    task automatic rand_w();
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < 4; k++) wa[j][k] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    task automatic a_load(input int gapmax);
        int t, g;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 4; k++) begin
                ba.ld_valid = 1'b1;
                ba.ld_data  = 16'(wa[j][k]);
                t = 0;
                while (!ba.ld_ready && t < 50) begin tick; t++; end
                chk("ld_wait", 64'(t < 50), 64'd1);
                tick;
                ba.ld_valid = 1'b0;
                if (j == 1 && k == 3) begin
                    #1 chk("ld_loaded", {ba.loaded, ba.in_ready}, 2'b11);
                end else begin
                    g = $urandom_range(0, gapmax);
                    for (int c = 0; c <= g; c++) begin
                        #1 chk("ld_gap", {ba.loaded, ba.in_ready}, 2'b00);
                        if (c < g) tick;
                    end
                end
            end
        end
    endtask

    task automatic a_run(input logic [47:0] v, output int lat);
        int t;
        ba.nx = v;
        ba.in_valid = 1'b1;
        t = 0;
        #1;
        while (!ba.in_ready && t < 50) begin tick; #1; t++; end
        chk("in_wait", 64'(t < 50), 64'd1);
        tick;
        ba.in_valid = 1'b0;
        ba.nx = rand_vec();
        lat = 0;
        while (!ba.out_valid && lat < 50) begin tick; lat++; end
    endtask

    task automatic a_ack;
        ba.out_ready = 1'b1;
        tick;
        ba.out_ready = 1'b0;
        chk("ack_clr", ba.out_valid, 1'b0);
    endtask

    task automatic b_load(input int w0, input int w1, input int b0);
        int ws [3];
        ws = '{w0, w1, b0};
        for (int k = 0; k < 3; k++) begin
            bb.ld_valid = 1'b1;
            bb.ld_data  = 16'(ws[k]);
            #1 chk("b_ldrdy", bb.ld_ready, 1'b1);
            tick;
        end
        bb.ld_valid = 1'b0;
        chk("b_loaded", {bb.loaded, bc.loaded}, 2'b11);
    endtask

    task automatic b_run(input logic [31:0] v, input logic [15:0] es, input logic [15:0] ew);
        bb.nx = v;
        bb.in_valid = 1'b1;
        #1 chk("b_inrdy", bb.in_ready, 1'b1);
        tick;
        bb.in_valid = 1'b0;
        repeat (3) tick;
        chk("b_ov", {bb.out_valid, bc.out_valid}, 2'b11);
        chk("b_sat", bb.lz, es);
        chk("b_wrap", bc.lz, ew);
        chk("b_ident", {bb.ly, bc.ly}, {es, ew});
        bb.out_ready = 1'b1;
        tick;
        bb.out_ready = 1'b0;
    endtask

    initial begin
        logic [47:0] v, v2;
        logic [31:0] ez, ey;
        logic [63:0] q [$];
        logic [63:0] e;
        int lat, sent, got, last;
        bit acc;

        rst = 1'b0;
        {ba.ld_valid, ba.in_valid, ba.out_ready, bb.ld_valid, bb.in_valid, bb.out_ready} = '0;
        ba.ld_data = '0; ba.nx = '0; bb.ld_data = '0; bb.nx = '0;
        tick; tick;
        rst = 1'b1;
        #1;
        chk("rst_a", {ba.out_valid, ba.loaded, ba.in_ready, ba.ly, ba.lz}, '0);
        chk("rst_b", {bb.out_valid, bb.loaded, bc.loaded, bb.lz, bc.lz}, '0);

        // Directed example: z0=2.25, z1=-7.0 (ReLU -> 0)
        wa[0] = '{256, 128, -512, 64};
        wa[1] = '{-256, -256, -256, 0};
        a_load(2);
        v = {16'd256, 16'd1024, 16'd512};
        a_run(v, lat);
        chk("dir_lat", 64'(lat), 64'd4);
        chk("dir_lz", ba.lz, {16'hF900, 16'h0240});
        chk("dir_ly", ba.ly, {16'h0000, 16'h0240});
        chk("dir_mdl", ba.lz, mdl_lz(v));
        a_ack;

        // Saturate vs wrap
        b_load(25600, 25600, 0);
        b_run({16'd25600, 16'd25600}, 16'h7FFF, 16'h2000);
        b_load(25600, -25600, 0);
        b_run({16'd25600, 16'h9C00}, 16'h8000, 16'hE000);

        // Random weights, backpressure with a held input
        rand_w();
        a_load(3);
        v = rand_vec();
        a_run(v, lat);
        ez = mdl_lz(v);
        ey = mdl_ly(ez);
        chk("bp_lat", 64'(lat), 64'd4);
        v2 = rand_vec();
        ba.nx = v2;
        ba.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1 chk("bp_hold", {ba.out_valid, ba.in_ready, ba.ly, ba.lz}, {2'b10, ey, ez});
            tick;
        end
        ba.out_ready = 1'b1;
        tick;
        ba.out_ready = 1'b0;
        #1 chk("bp_post", {ba.out_valid, ba.in_ready}, 2'b01);
        tick;
        ba.in_valid = 1'b0;
        lat = 0;
        while (!ba.out_valid && lat < 50) begin tick; lat++; end
        chk("bp2_lat", 64'(lat), 64'd4);
        chk("bp2_res", {ba.ly, ba.lz}, {mdl_ly(mdl_lz(v2)), mdl_lz(v2)});
        a_ack;

        // Back-to-back stream
        ba.out_ready = 1'b1;
        ba.nx = rand_vec();
        ba.in_valid = 1'b1;
        sent = 0; got = 0; last = -1;
        for (int c = 0; c < 300 && got < 6; c++) begin
            #1;
            acc = ba.in_valid & ba.in_ready;
            if (ba.out_valid) begin
                if (q.size() > 0) e = q.pop_front();
                else e = '1;
                chk("b2b_res", {ba.ly, ba.lz}, e);
                if (last >= 0) chk("b2b_gap", 64'(c - last), 64'd6);
                last = c;
                got++;
            end
            if (acc) begin
                ez = mdl_lz(ba.nx);
                q.push_back({mdl_ly(ez), ez});
                sent++;
            end
            tick;
            if (acc) begin
                ba.nx = rand_vec();
                if (sent == 6) ba.in_valid = 1'b0;
            end
        end
        ba.out_ready = 1'b0;
        chk("b2b_cnt", 64'(got), 64'd6);

        // Reload while idle; result must use only the new set
        rand_w();
        a_load(4);
        v = rand_vec();
        a_run(v, lat);
        chk("rl_res", {ba.ly, ba.lz}, {mdl_ly(mdl_lz(v)), mdl_lz(v)});
        a_ack;

        // Reset in the middle of a computation
        v = rand_vec();
        ba.nx = v;
        ba.in_valid = 1'b1;
        tick;
        tick; tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        #1 chk("rc_clr", {ba.out_valid, ba.loaded, ba.in_ready, ba.ly, ba.lz}, '0);
        for (int c = 0; c < 6; c++) begin
            tick;
            chk("rc_idle", {ba.out_valid, ba.in_ready}, 2'b00);
        end
        ba.in_valid = 1'b0;
        rand_w();
        a_load(1);
        v = rand_vec();
        a_run(v, lat);
        chk("rc_lat", 64'(lat), 64'd4);
        chk("rc_res", {ba.ly, ba.lz}, {mdl_ly(mdl_lz(v)), mdl_lz(v)});
        a_ack;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule
